inst_fetch: RTL and testbench

//  Instruction-fetch stage that feeds the control decoder: owns the PC, drives instRam reads and splits the word into opcode/funct/rt.

---
 rtl/inst_fetch_pkg.sv | 36 +++
 rtl/inst_fetch_pc_next_sel.sv | 43 ++++
 rtl/inst_fetch.sv | 168 ++++++++++++++++
 tb/tb_inst_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   - pc mux bit indices (one-hot select coming from the control decoder)
//   - instruction field positions used to split the fetched word
//   - default reset / exception vectors
//   - fetched-word record and a word-alignment helper
package inst_fetch_pkg;

  localparam int PC_MUX_W = 5;
  localparam int MUX_SEQ  = 0;
  localparam int MUX_BR   = 1;
  localparam int MUX_JMP  = 2;
  localparam int MUX_REG  = 3;
  localparam int MUX_EXC  = 4;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int JIDX_HI  = 25;

  localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC0_0380;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } fetchWord_t;

  function automatic logic [31:0] alignWord(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   curPc         PC of the word being accepted
//   instIndex     jump index field of that word
//   redirectValid qualifies pcMux
//   pcMux         one-hot select (b0 seq, b1 branch, b2 jump, b3 register, b4 exception)
//   brTarget      branch target
//   regTarget     jr/jalr target
//   seqPc         curPc + 4 (wraps at 2^32)
//   redirect      a non-sequential target was selected
//   isExc         the selected target is the exception vector
//   target        selected target (priority b4 > b3 > b2 > b1 > seq)
module pc_next_sel
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [31:0]         curPc,
  input  logic [JIDX_HI:0]    instIndex,
  input  logic                redirectValid,
  input  logic [PC_MUX_W-1:0] pcMux,
  input  logic [31:0]         brTarget,
  input  logic [31:0]         regTarget,
  output logic [31:0]         seqPc,
  output logic                redirect,
  output logic                isExc,
  output logic [31:0]         target
);

  always_comb begin
    seqPc  = curPc + 32'd4;
    target = seqPc;
    if      (pcMux[MUX_EXC]) target = EXC_VECTOR;
    else if (pcMux[MUX_REG]) target = regTarget;
    else if (pcMux[MUX_JMP]) target = {seqPc[31:28], instIndex, 2'b00};
    else if (pcMux[MUX_BR])  target = brTarget;
  end

  // b0 alone (or nothing) is just the sequential path, which fetch issues anyway.
  assign redirect = redirectValid && (|pcMux[MUX_EXC:MUX_BR]);
  assign isExc    = redirectValid && pcMux[MUX_EXC];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues instRam reads and hands words to decode
// over a valid/ready handshake.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   inst_ram_en/wen/addr/rdata       synchronous-read instruction RAM (wen tied 0)
//   redirect_valid, ctl_pcValue_mux  pc mux from decode, sampled on accept
//   br_target, reg_target            redirect targets
//   id_valid/id_ready                handshake towards decode
//   id_inst/pc/opcode/funct/rt/adel  delivered word and its fields
// Configuration: FETCH_DELAY_SLOT_EN delivers the word after a non-exception
// redirect as a delay slot; undefined, that word is squashed.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                inst_ram_en,
  output logic                inst_ram_wen,
  output logic [31:0]         inst_ram_addr,
  input  logic [31:0]         inst_ram_rdata,
  input  logic                redirect_valid,
  input  logic [PC_MUX_W-1:0] ctl_pcValue_mux,
  input  logic [31:0]         br_target,
  input  logic [31:0]         reg_target,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_inst,
  output logic [31:0]         id_pc,
  output logic [5:0]          id_opcode,
  output logic [5:0]          id_funct,
  output logic [5:0]          id_rt,
  output logic                id_adel
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

`ifdef FETCH_DELAY_SLOT_EN
  localparam logic DELAY_SLOT = 1'b1;
`else
  localparam logic DELAY_SLOT = 1'b0;
`endif

  logic [1:0]  state;
  // word requested last cycle, its rdata is on inst_ram_rdata now
  logic        flightValid;
  logic        flightAdel;
  logic [31:0] flightPc;
  fetchWord_t  hold;
  // redirect accepted but not yet requested (the sequential word went out first)
  logic        pendValid;
  logic        pendExc;
  logic [31:0] pendTarget;

  fetchWord_t  cur;
  logic        curValid;
  logic        squash;
  logic        idValid;
  logic        accept;
  logic [31:0] seqPc;
  logic [31:0] target;
  logic        redirect;
  logic        isExc;
  logic        reqEn;
  logic [31:0] reqRaw;

  always_comb begin
    cur      = '0;
    curValid = 1'b0;
    case (state)
      S_RUN: begin
        cur.inst = inst_ram_rdata;
        cur.pc   = flightPc;
        cur.adel = flightAdel;
        curValid = flightValid;
      end
      S_STALL: begin
        cur      = hold;
        curValid = 1'b1;
      end
      default: ;
    endcase
  end

  // With a redirect pending, the word on the bus is the one after the redirecting word.
  assign squash  = pendValid && (!DELAY_SLOT || pendExc);
  assign idValid = curValid && !squash;
  assign accept  = idValid && id_ready;

  pc_next_sel #(.EXC_VECTOR(EXC_VECTOR)) uNextSel (
    .curPc         (cur.pc),
    .instIndex     (cur.inst[JIDX_HI:0]),
    .redirectValid (redirect_valid),
    .pcMux         (ctl_pcValue_mux),
    .brTarget      (br_target),
    .regTarget     (reg_target),
    .seqPc         (seqPc),
    .redirect      (redirect),
    .isExc         (isExc),
    .target        (target)
  );

  // Never request while a word waits on decode: the RAM has no second slot.
  always_comb begin
    reqEn  = 1'b0;
    reqRaw = RESET_PC;
    if (state == S_BOOT) begin
      reqEn = 1'b1;
    end else begin
      reqEn  = idValid ? id_ready : pendValid;
      reqRaw = pendValid ? pendTarget : seqPc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_BOOT;
      flightValid <= 1'b0;
      flightAdel  <= 1'b0;
      flightPc    <= RESET_PC;
      hold        <= '0;
      pendValid   <= 1'b0;
      pendExc     <= 1'b0;
      pendTarget  <= '0;
    end else begin
      flightValid <= reqEn;
      if (reqEn) begin
        flightPc   <= alignWord(reqRaw);
        flightAdel <= |reqRaw[1:0];
      end
      // A redirect carried by a delay-slot word is dropped: the pending target wins.
      if (pendValid) begin
        if (reqEn) pendValid <= 1'b0;
      end else if (accept && redirect) begin
        pendValid  <= 1'b1;
        pendExc    <= isExc;
        pendTarget <= target;
      end
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (idValid && !id_ready) begin
                   state <= S_STALL;
                   hold  <= cur;
                 end
        S_STALL: if (id_ready) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
    end
  end

  // The boot request is combinational from state, so hold it low while reset is asserted.
  assign inst_ram_en   = reqEn && resetn;
  assign inst_ram_wen  = 1'b0;
  assign inst_ram_addr = resetn ? alignWord(reqRaw) : '0;

  assign id_valid  = idValid;
  assign id_inst   = cur.inst;
  assign id_pc     = cur.pc;
  assign id_adel   = cur.adel;
  assign id_opcode = cur.inst[OP_HI:OP_LO];
  assign id_funct  = cur.inst[FUNCT_HI:FUNCT_LO];
  assign id_rt     = {1'b0, cur.inst[RT_HI:RT_LO]};

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS_ON = 1'b1;
`else
  localparam bit DS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_ram_en, inst_ram_wen;
  logic [31:0] inst_ram_addr;
  logic [31:0] inst_ram_rdata = '0;
  logic        redirect_valid;
  logic [4:0]  ctl_pcValue_mux;
  logic [31:0] br_target, reg_target;
  logic        id_valid, id_ready, id_adel;
  logic [31:0] id_inst, id_pc;
  logic [5:0]  id_opcode, id_funct, id_rt;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .resetn(resetn),
    .inst_ram_en(inst_ram_en), .inst_ram_wen(inst_ram_wen),
    .inst_ram_addr(inst_ram_addr), .inst_ram_rdata(inst_ram_rdata),
    .redirect_valid(redirect_valid), .ctl_pcValue_mux(ctl_pcValue_mux),
    .br_target(br_target), .reg_target(reg_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rt(id_rt), .id_adel(id_adel)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'hBFC0_0008) return 32'h0062_0820;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // synchronous-read instruction RAM
  always @(posedge clk) if (inst_ram_en) inst_ram_rdata <= memWord(inst_ram_addr);

  typedef struct {
    logic [31:0] pc;
    logic        adel;
    bit          ds;
  } expWord_t;

  expWord_t expQ[$];
  int       expBubble;
  int       nTests, nFail;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    expQ.push_back('{pc: RST_PC, adel: 1'b0, ds: 1'b0});
    expBubble = 0;
  endtask

  // Deassert reset away from the edge, check the boot request, land on the first run cycle.
  task automatic boot();
    @(negedge clk);
    resetn = 1'b1;
    id_ready = 1'b1;
    #1;
    chk32("boot_en", {31'd0, inst_ram_en}, 32'd1);
    chk32("boot_addr", inst_ram_addr, RST_PC);
    chk32("boot_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #2;
    modelReset();
  endtask

  // One cycle: check delivered word against the stream model, drive decode's
  // response, check the request that results, then advance to the next cycle.
  task automatic step(input bit rdy, input bit rv, input logic [4:0] mux,
                      input logic [31:0] br, input logic [31:0] rg);
    expWord_t    w;
    bit          expValid, squashNow;
    logic [31:0] seq, tgt, inst, expAddr;
    w = '{pc: '0, adel: 1'b0, ds: 1'b0};
    expValid  = (expBubble == 0);
    squashNow = 1'b0;
    seq       = '0;
    chk32("id_valid", {31'd0, id_valid}, {31'd0, expValid});
    if (expValid) begin
      w = expQ[0];
      chk32("id_pc", id_pc, w.pc);
      chk32("id_inst", id_inst, memWord(w.pc));
      chk32("id_adel", {31'd0, id_adel}, {31'd0, w.adel});
    end
    id_ready        = rdy;
    redirect_valid  = rv && expValid && !w.ds;
    ctl_pcValue_mux = mux;
    br_target       = br;
    reg_target      = rg;
    if (!expValid) begin
      expBubble--;
    end else if (rdy) begin
      void'(expQ.pop_front());
      seq = w.pc + 32'd4;
      if (redirect_valid && mux[4:1] != 4'd0) begin
        inst = memWord(w.pc);
        if      (mux[4]) tgt = EXC_PC;
        else if (mux[3]) tgt = rg;
        else if (mux[2]) tgt = {seq[31:28], inst[25:0], 2'b00};
        else             tgt = br;
        expQ.delete();
        if (DS_ON && !mux[4]) begin
          expQ.push_back('{pc: seq, adel: 1'b0, ds: 1'b1});
        end else begin
          squashNow = 1'b1;
          expBubble = 1;
        end
        expQ.push_back('{pc: {tgt[31:2], 2'b00}, adel: |tgt[1:0], ds: 1'b0});
      end else if (expQ.size() == 0) begin
        expQ.push_back('{pc: seq, adel: 1'b0, ds: 1'b0});
      end
    end
    #1;
    chk32("ram_en", {31'd0, inst_ram_en}, {31'd0, (!expValid || rdy)});
    chk32("ram_wen", {31'd0, inst_ram_wen}, 32'd0);
    if (!expValid || rdy) begin
      expAddr = squashNow ? seq : expQ[0].pc;
      chk32("ram_addr", inst_ram_addr, expAddr);
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, '0, '0);
  endtask

  initial begin
    logic [31:0] r1, r2;
    bit          rdy, rv;
    logic [4:0]  mux;
    nTests = 0; nFail = 0;
    resetn = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    ctl_pcValue_mux = '0; br_target = '0; reg_target = '0;
    modelReset();
    #12;
    chk32("rst_en", {31'd0, inst_ram_en}, 32'd0);
    chk32("rst_addr", inst_ram_addr, 32'd0);
    chk32("rst_valid", {31'd0, id_valid}, 32'd0);
    chk32("rst_pc", id_pc, 32'd0);
    chk32("rst_inst", id_inst, 32'd0);

    boot();
    idle(2);                                   // BFC0_0000, 04 delivered
    chk32("add_opcode", {26'd0, id_opcode}, 32'h00);
    chk32("add_funct", {26'd0, id_funct}, 32'h20);
    chk32("add_rt", {26'd0, id_rt}, 32'h02);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, '0, '0);  // stall
    idle(2);

    step(1'b1, 1'b1, 5'b01000, '0, 32'h0000_0100);             // reach 0x100
    for (int i = 0; i < 3 && !(id_valid && id_pc == 32'h100); i++) idle(1);
    chk32("at_0x100", id_pc, 32'h100);
    step(1'b1, 1'b1, 5'b00010, 32'h0000_0200, '0);             // branch
    idle(3);

    step(1'b1, 1'b1, 5'b10010, 32'h0000_0400, '0);             // exc beats branch
    idle(3);

    step(1'b1, 1'b1, 5'b01000, '0, 32'h0000_0302);             // misaligned
    idle(3);

    step(1'b1, 1'b1, 5'b01000, '0, 32'hFFFF_FFF8);             // wrap
    idle(4);

    step(1'b1, 1'b1, 5'b00100, '0, '0);                        // jump
    idle(2);

    step(1'b0, 1'b0, 5'd0, '0, '0);                            // reset mid-stall
    step(1'b0, 1'b0, 5'd0, '0, '0);
    resetn = 1'b0;
    #1;
    chk32("rs_en", {31'd0, inst_ram_en}, 32'd0);
    chk32("rs_addr", inst_ram_addr, 32'd0);
    chk32("rs_valid", {31'd0, id_valid}, 32'd0);
    chk32("rs_pc", id_pc, 32'd0);
    chk32("rs_inst", id_inst, 32'd0);
    chk32("rs_adel", {31'd0, id_adel}, 32'd0);
    boot();
    idle(3);

    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(3) == 0);
      mux = 5'($urandom_range(31));
      r1  = $urandom();
      r2  = $urandom();
      if ($urandom_range(1) == 0) r1 = {r1[31:2], 2'b00};
      if ($urandom_range(1) == 0) r2 = {r2[31:2], 2'b00};
      step(rdy, rv, mux, r1, r2);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
